// File: rtl/kulisch_pkg.sv
// Shared constants and FSM encoding for the Kulisch accumulator and its FP32 resolver.
package kulisch_pkg;

   localparam int unsigned AWIDTH     = 92;
   localparam int unsigned FRAC       = 48;
   localparam int unsigned CHUNK      = 23;
   localparam int unsigned NCHUNK     = AWIDTH / CHUNK;
   localparam int unsigned FP32_BIAS  = 127;
   localparam int unsigned FP32_MBITS = 23;
   localparam int unsigned POS_W      = $clog2(AWIDTH);
   localparam int unsigned CNT_W      = $clog2(NCHUNK);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_NORM,
      ST_PACK,
      ST_DONE
   } state_e;

endpackage

// File: rtl/kulisch_lzc.sv
// Leading-one position and all-zero flag of an unsigned vector (combinational).
module kulisch_lzc #(
   parameter int unsigned WIDTH = 92,
   parameter int unsigned PW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [PW-1:0]    pos_c_o,
   output logic             zero_c_o
);

   // Highest set bit wins since later iterations overwrite earlier ones.
   always_comb begin
      pos_c_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (vec_i[i]) pos_c_o = PW'(i);
      end
      zero_c_o = ~|vec_i;
   end

endmodule

// File: rtl/kulisch_resolve_fp32.sv
// Resolves a sum/carry Kulisch accumulator into a round-to-nearest-even FP32 value
// using a chunked carry-propagate adder, leading-one normalisation and a pack stage.
module kulisch_resolve_fp32
   import kulisch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [AWIDTH-1:0] i_sum_acc,
   input  logic [AWIDTH-1:0] i_carry_acc,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [31:0]       o_fp32,
   output logic              o_inexact
);

   localparam int unsigned CW1    = CHUNK + 1;
   localparam int unsigned NORM_W = AWIDTH - 1;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned EM_W   = EXP_W + FP32_MBITS;

   state_e              state_q, state_d;
   logic [AWIDTH-1:0]   sum_q, sum_d, carry_q, carry_d, res_q, res_d, mag_q, mag_d;
   logic                cin_q, cin_d, sign_q, sign_d, zero_q, zero_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [31:0]         fp_q, fp_d;
   logic                inexact_q, inexact_d, valid_q, valid_d, ready_q, ready_d;

   logic [CW1-1:0]      chunk_c;
   logic [AWIDTH-1:0]   mag_c;
   logic [POS_W-1:0]    lzc_pos_c, shamt_c;
   logic                lzc_zero_c, guard_c, sticky_c, round_c;
   logic [NORM_W-1:0]   norm_c;
   logic [EXP_W-1:0]    exp_c;
   logic [EM_W-1:0]     em_c;

   assign mag_c = res_q[AWIDTH-1] ? -res_q : res_q;

   kulisch_lzc #(
      .WIDTH (AWIDTH),
      .PW    (POS_W)
   ) u_lzc (
      .vec_i    (mag_c),
      .pos_c_o  (lzc_pos_c),
      .zero_c_o (lzc_zero_c)
   );

   // Pack datapath: shift the leading one out of the top, leaving mantissa/guard/sticky in place.
   always_comb begin
      chunk_c  = CW1'(sum_q[CHUNK-1:0]) + CW1'(carry_q[CHUNK-1:0]) + CW1'(cin_q);
      shamt_c  = POS_W'(AWIDTH - 1) - pos_q;
      norm_c   = NORM_W'(mag_q << shamt_c);
      exp_c    = EXP_W'(pos_q) + EXP_W'(FP32_BIAS - FRAC);
      em_c     = {exp_c, norm_c[NORM_W-1 -: FP32_MBITS]};
      guard_c  = norm_c[NORM_W-1-FP32_MBITS];
      sticky_c = |norm_c[NORM_W-2-FP32_MBITS:0];
      round_c  = guard_c & (sticky_c | em_c[0]);
   end

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      res_d     = res_q;
      cin_d     = cin_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      mag_d     = mag_q;
      pos_d     = pos_q;
      zero_d    = zero_q;
      fp_d      = fp_q;
      inexact_d = inexact_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               sum_d   = i_sum_acc;
               carry_d = i_carry_acc;
               cin_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            // Operands shift down one chunk per cycle; result fills in from the top.
            res_d   = {chunk_c[CHUNK-1:0], res_q[AWIDTH-1:CHUNK]};
            sum_d   = sum_q >> CHUNK;
            carry_d = carry_q >> CHUNK;
            cin_d   = chunk_c[CHUNK];
            if (cnt_q == CNT_W'(NCHUNK - 1)) begin
               cnt_d   = '0;
               cin_d   = 1'b0;
               state_d = ST_NORM;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_NORM: begin
            sign_d  = res_q[AWIDTH-1];
            mag_d   = mag_c;
            pos_d   = lzc_pos_c;
            zero_d  = lzc_zero_c;
            state_d = ST_PACK;
         end
         ST_PACK: begin
            // Rounding carry ripples from mantissa into exponent naturally.
            if (zero_q) begin
               fp_d      = '0;
               inexact_d = 1'b0;
            end else begin
               fp_d      = {sign_q, em_c + EM_W'(round_c)};
               inexact_d = guard_c | sticky_c;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      valid_d = (state_d == ST_DONE);
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sum_q     <= '0;
         carry_q   <= '0;
         res_q     <= '0;
         cin_q     <= 1'b0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         pos_q     <= '0;
         zero_q    <= 1'b0;
         fp_q      <= '0;
         inexact_q <= 1'b0;
         valid_q   <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         res_q     <= res_d;
         cin_q     <= cin_d;
         cnt_q     <= cnt_d;
         sign_q    <= sign_d;
         mag_q     <= mag_d;
         pos_q     <= pos_d;
         zero_q    <= zero_d;
         fp_q      <= fp_d;
         inexact_q <= inexact_d;
         valid_q   <= valid_d;
         ready_q   <= ready_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_ready   = ready_q;
   assign o_fp32    = fp_q;
   assign o_inexact = inexact_q;

endmodule

// File: tb/tb_kulisch_resolve_fp32.sv
// Directed-vector bench for kulisch_resolve_fp32 with hand-computed FP32 results.
module tb_kulisch_resolve_fp32;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [91:0] i_sum_acc;
   logic [91:0] i_carry_acc;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_fp32;
   logic        o_inexact;

   int checks   = 0;
   int failures = 0;

   kulisch_resolve_fp32 dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_sum_acc   (i_sum_acc),
      .i_carry_acc (i_carry_acc),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_fp32      (o_fp32),
      .o_inexact   (o_inexact)
   );

   always #5 clk = ~clk;

   // Drives one transaction from IDLE, returns result and edges from accept to o_valid.
   task automatic do_txn(input logic [91:0] s, input logic [91:0] c,
                         output logic [31:0] fp, output logic inx, output int lat);
      @(negedge clk);
      i_sum_acc   = s;
      i_carry_acc = c;
      i_valid     = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      fp  = o_fp32;
      inx = o_inexact;
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1 i_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
      i_sum_acc = '0; i_carry_acc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_fp32 !== 32'h0 || o_inexact !== 1'b0) begin
         failures++;
         $display("FAIL reset: valid=%b ready=%b fp=%h inx=%b, want 0 1 00000000 0",
                  o_valid, o_ready, o_fp32, o_inexact);
      end
      rst = 1'b0;
   endtask

   // Runs one vector and compares value, inexact flag and latency.
   task automatic test_vector(input string name, input logic [91:0] s, input logic [91:0] c,
                              input logic [31:0] exp_fp, input logic exp_inx);
      logic [31:0] fp;
      logic        inx;
      int          lat;
      do_txn(s, c, fp, inx, lat);
      checks++;
      if (fp !== exp_fp || inx !== exp_inx) begin
         failures++;
         $display("FAIL %s: got fp=%h inx=%b, want fp=%h inx=%b", name, fp, inx, exp_fp, exp_inx);
      end
      checks++;
      if (lat !== 6) begin
         failures++;
         $display("FAIL %s_latency: got %0d edges, want 6", name, lat);
      end
   endtask

   task automatic test_basic();
      logic [91:0] ones;
      ones = '1;
      test_vector("one",        92'd1 << 48, 92'd0, 32'h3F800000, 1'b0);
      test_vector("ripple",     ones, (92'd3 << 48) + 92'd1, 32'h40400000, 1'b0);
      test_vector("neg_half",   ones << 47, 92'd0, 32'hBF000000, 1'b0);
      test_vector("most_neg",   92'd1 << 91, 92'd0, 32'hD5000000, 1'b0);
      test_vector("lsb_only",   92'd1, 92'd0, 32'h27800000, 1'b0);
   endtask

   task automatic test_rounding();
      test_vector("tie_even",   (92'd1 << 72) + (92'd1 << 48), 92'd0, 32'h4B800000, 1'b1);
      test_vector("tie_odd",    (92'd1 << 72) + (92'd3 << 48), 92'd0, 32'h4B800002, 1'b1);
      test_vector("exp_carry",  (92'd1 << 73) - (92'd1 << 48), 92'd0, 32'h4C000000, 1'b1);
   endtask

   task automatic test_zero();
      logic [91:0] x;
      x = 92'h1234567_89AB_CDEF_0123_4567;
      test_vector("zero", x, 92'd0 - x, 32'h00000000, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [91:0] ones;
      int          lat;
      ones = '1;
      @(negedge clk);
      i_sum_acc = 92'd1 << 48; i_carry_acc = '0; i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      // New request arrives while the result is stalled.
      i_sum_acc = ones; i_carry_acc = (92'd3 << 48) + 92'd1; i_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_fp32 !== 32'h3F800000) begin
            failures++;
            $display("FAIL stall_%0d: valid=%b ready=%b fp=%h, want 1 0 3f800000",
                     k, o_valid, o_ready, o_fp32);
         end
         @(posedge clk);
      end
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1 i_ready = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL release: valid=%b ready=%b, want 0 1", o_valid, o_ready);
      end
      @(posedge clk);
      #1 i_valid = 1'b0;
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      checks++;
      if (o_fp32 !== 32'h40400000 || lat !== 6) begin
         failures++;
         $display("FAIL after_stall: got fp=%h lat=%0d, want fp=40400000 lat=6", o_fp32, lat);
      end
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1 i_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      i_sum_acc = (92'd1 << 72) + (92'd1 << 48); i_carry_acc = '0; i_valid = 1'b1;
      @(posedge clk);
      #1 i_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset: valid=%b ready=%b, want 0 1", o_valid, o_ready);
      end
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1 if (o_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL no_partial: got %0d valid cycles, want 0", seen);
      end
      test_vector("post_reset", (92'd1 << 73) - (92'd1 << 48), 92'd0, 32'h4C000000, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [91:0] vs [3];
      logic [31:0] ve [3];
      int          waitc;
      vs[0] = 92'd1 << 48;                     ve[0] = 32'h3F800000;
      vs[1] = 92'd0 - (92'd1 << 47);           ve[1] = 32'hBF000000;
      vs[2] = (92'd1 << 72) + (92'd3 << 48);   ve[2] = 32'h4B800002;
      @(negedge clk);
      i_ready = 1'b1; i_valid = 1'b1;
      i_sum_acc = vs[0]; i_carry_acc = '0;
      for (int k = 0; k < 3; k++) begin
         waitc = 0;
         while (!o_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
         end
         @(posedge clk);
         #1;
         if (k < 2) i_sum_acc = vs[k+1];
         waitc = 0;
         while (!o_valid && waitc < 40) begin
            @(posedge clk);
            #1 waitc++;
         end
         checks++;
         if (o_fp32 !== ve[k] || o_ready !== 1'b0 || waitc !== 6) begin
            failures++;
            $display("FAIL b2b_%0d: got fp=%h ready=%b lat=%0d, want fp=%h ready=0 lat=6",
                     k, o_fp32, o_ready, waitc, ve[k]);
         end
      end
      @(posedge clk);
      #1 i_valid = 1'b0; i_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
